// File: rtl/slave_mem_responder_pkg.sv
// Shared master/slave protocol constants for the crossbar fabric.
// cross_bar, the bench masters and the memory responder all import m_s_pkg.
package m_s_pkg;

    localparam logic        CMD_READ          = 1'b0;
    localparam logic        CMD_WRITE         = 1'b1;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ms_state_e;

    // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/slave_mem_responder_if.sv
// Crossbar slave-port bundle: request/addr/cmd/wdata toward the slave,
// ack/rdata back toward the master.
interface slave_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              cmd;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, cmd, wdata, input ack, rdata);
    modport slave  (input req, addr, cmd, wdata, output ack, rdata);
endinterface

// File: rtl/slave_mem_responder_lfsr16_gen.sv
// Free-running 16-bit Fibonacci LFSR; also used by bench masters for jitter.
// A zero seed would lock the register, so it is swapped for the default.
module lfsr16_gen
    import m_s_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

    // Advance one step per clock; reload the seed on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= seed_eff;
        end else begin
            out <= lfsr16_next(out);
        end
    end

endmodule

// File: rtl/slave_mem_responder.sv
// Memory-backed crossbar slave. Acks each request after a pseudo-random wait
// taken from the LFSR, writes or reads one word of the internal array on the
// accepting edge, and flags a master that drops req before it was acked.
//
// state | meaning
// IDLE  | no request pending; ack at once if the sampled wait is zero
// WAIT  | request seen, counting down the remaining wait cycles in cnt
module slave_mem_responder
    import m_s_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int          MEM_DEPTH = 256,
    parameter int          WAIT_BITS = 2,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    slave_mem_responder_if.slave  bus,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt,
    output logic                  proto_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = (WAIT_BITS > 0) ? WAIT_BITS : 1;

    logic [15:0]       lfsr;
    logic [CNT_W-1:0]  wait_val;
    logic [CNT_W-1:0]  cnt;
    ms_state_e         state;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              unused_bits;

    lfsr16_gen u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .out   (lfsr)
    );

    generate
        if (WAIT_BITS > 0) begin : g_wait
            assign wait_val = lfsr[CNT_W-1:0];
        end else begin : g_nowait
            assign wait_val = '0;
        end
    endgenerate

    assign idx         = bus.addr[IDX_W+1:2];
    assign unused_bits = ^{bus.addr, lfsr};

    // Ack is combinational from req; reset masks it so nothing is accepted.
    always_comb begin
        accept = 1'b0;
        if (!reset && bus.req) begin
            if (state == IDLE) begin
                accept = (wait_val == '0);
            end else begin
                accept = (cnt == '0);
            end
        end
    end

    assign bus.ack   = accept;
    assign bus.rdata = rdata_q;

    // Handshake FSM, read port, counters and protocol-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            proto_err <= 1'b0;
            wr_cnt    <= 16'd0;
            rd_cnt    <= 16'd0;
            rdata_q   <= '0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req && wait_val != '0) begin
                        cnt   <= wait_val - CNT_W'(1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.req) begin
                        state     <= IDLE;
                        proto_err <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                if (bus.cmd == CMD_WRITE) begin
                    wr_cnt <= wr_cnt + 16'd1;
                end else begin
                    rd_cnt  <= rd_cnt + 16'd1;
                    rdata_q <= mem[idx];
                end
            end
        end
    end

    // Word array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.cmd == CMD_WRITE) begin
            mem[idx] <= bus.wdata;
        end
    end

endmodule

// File: tb/tb_slave_mem_responder.sv
// Directed bench for slave_mem_responder: a zero-wait instance for data-path
// and throughput checks, and a WAIT_BITS=2 instance whose wait times are
// predicted by a bench-side LFSR model.
module tb_slave_mem_responder;
    import m_s_pkg::*;

    logic clk = 1'b0;
    logic rst0;
    logic rst2;
    logic [15:0] wr0, rd0, wr2, rd2;
    logic perr0, perr2;
    logic [15:0] m_lfsr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    slave_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    slave_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

    slave_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_BITS(0), .SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0),
        .wr_cnt(wr0), .rd_cnt(rd0), .proto_err(perr0)
    );

    slave_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_BITS(2), .SEED(16'h0001)
    ) dut2 (
        .clk(clk), .reset(rst2), .bus(bus2),
        .wr_cnt(wr2), .rd_cnt(rd2), .proto_err(perr2)
    );

    // Reference LFSR for dut2: taps 16,14,13,11, reloaded with the seed on reset.
    always @(posedge clk) begin
        if (rst2) m_lfsr <= 16'h0001;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One zero-wait transfer on dut0: ack must appear in the request cycle.
    task automatic xfer0(input logic cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
        bus0.req   = 1'b1;
        bus0.cmd   = cmd;
        bus0.addr  = addr;
        bus0.wdata = wdata;
        @(negedge clk);
        check("ack0_same_cycle", {31'd0, bus0.ack}, 32'd1);
        @(posedge clk); #1;
        if (cmd == CMD_READ) check("rdata0", bus0.rdata, exp_rdata);
    endtask

    // One transfer on dut2 with req held until ack; latency checked against the model.
    task automatic xfer2(input logic cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata);
        int lat;
        int exp_w;
        logic got;
        exp_w      = int'(m_lfsr[1:0]);
        lat        = 0;
        got        = 1'b0;
        bus2.req   = 1'b1;
        bus2.cmd   = cmd;
        bus2.addr  = addr;
        bus2.wdata = wdata;
        while (!got && lat < 8) begin
            @(negedge clk);
            if (bus2.ack === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check("ack2_seen", {31'd0, got}, 32'd1);
        check("ack2_latency", lat, exp_w);
        check("ack2_latency_le3", {31'd0, lat <= 3}, 32'd1);
        @(posedge clk); #1;
        bus2.req = 1'b0;
        rdata    = bus2.rdata;
    endtask

    // Idle dut2 until the model predicts wait = 3 for the current cycle.
    task automatic wait_for_w3();
        int n;
        n = 0;
        while (m_lfsr[1:0] != 2'd3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("w3_found", {31'd0, m_lfsr[1:0] == 2'd3}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst0 = 1'b1; rst2 = 1'b1;
        bus0.req = 1'b0; bus0.cmd = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        bus2.req = 1'b0; bus2.cmd = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst2 = 1'b0;

        // Reset state
        check("rst_ack0",   {31'd0, bus0.ack}, 32'd0);
        check("rst_rdata0", bus0.rdata, 32'd0);
        check("rst_wr0",    {16'd0, wr0}, 32'd0);
        check("rst_rd0",    {16'd0, rd0}, 32'd0);
        check("rst_perr0",  {31'd0, perr0}, 32'd0);
        check("rst_rdata2", bus2.rdata, 32'd0);
        check("rst_wr2",    {16'd0, wr2}, 32'd0);
        check("rst_perr2",  {31'd0, perr2}, 32'd0);

        // Zero-wait write then read of 0x10
        xfer0(CMD_WRITE, 32'h10, 32'hDEADBEEF, 32'h0);
        xfer0(CMD_READ,  32'h10, 32'h0, 32'hDEADBEEF);
        bus0.req = 1'b0;
        check("wr0_after_t1", {16'd0, wr0}, 32'd1);
        check("rd0_after_t1", {16'd0, rd0}, 32'd1);

        // Back-to-back: 8 writes then 8 reads, one per cycle
        for (int i = 0; i < 8; i++) xfer0(CMD_WRITE, 32'(i * 4), 32'(i), 32'h0);
        for (int i = 0; i < 8; i++) xfer0(CMD_READ,  32'(i * 4), 32'h0, 32'(i));
        bus0.req = 1'b0;
        check("wr0_after_b2b", {16'd0, wr0}, 32'd9);
        check("rd0_after_b2b", {16'd0, rd0}, 32'd9);

        // Upper address bits are ignored
        xfer0(CMD_WRITE, 32'h8000_0040, 32'h0000_1234, 32'h0);
        xfer0(CMD_READ,  32'h0000_0040, 32'h0, 32'h0000_1234);
        bus0.req = 1'b0;
        @(negedge clk);
        check("ack0_idle", {31'd0, bus0.ack}, 32'd0);
        check("wr0_after_alias", {16'd0, wr0}, 32'd10);
        check("rd0_after_alias", {16'd0, rd0}, 32'd10);
        @(posedge clk); #1;

        // Random waits on dut2
        xfer2(CMD_WRITE, 32'h20, 32'h5555_AAAA, rd);
        for (int k = 0; k < 3; k++) begin
            xfer2(CMD_READ, 32'h20, 32'h0, rd);
            check("rdata2_wait", rd, 32'h5555_AAAA);
            if (k == 1) begin
                @(posedge clk); #1;
            end
        end
        check("wr2_after_waits", {16'd0, wr2}, 32'd1);
        check("rd2_after_waits", {16'd0, rd2}, 32'd3);

        // Drop req while waiting with W=3
        wait_for_w3();
        bus2.req = 1'b1; bus2.cmd = CMD_WRITE; bus2.addr = 32'h20; bus2.wdata = 32'hFFFF_0000;
        @(negedge clk);
        check("drop_ack_c0", {31'd0, bus2.ack}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_ack_c1", {31'd0, bus2.ack}, 32'd0);
        @(posedge clk); #1;
        bus2.req = 1'b0;
        @(negedge clk);
        check("drop_ack_c2", {31'd0, bus2.ack}, 32'd0);
        check("drop_perr_before", {31'd0, perr2}, 32'd0);
        @(posedge clk); #1;
        check("drop_perr_pulse", {31'd0, perr2}, 32'd1);
        check("drop_wr2", {16'd0, wr2}, 32'd1);
        check("drop_rd2", {16'd0, rd2}, 32'd3);
        @(posedge clk); #1;
        check("drop_perr_clear", {31'd0, perr2}, 32'd0);
        xfer2(CMD_READ, 32'h20, 32'h0, rd);
        check("drop_mem_kept", rd, 32'h5555_AAAA);
        check("rd2_after_drop", {16'd0, rd2}, 32'd4);

        // Reset while in WAIT
        wait_for_w3();
        bus2.req = 1'b1; bus2.cmd = CMD_READ; bus2.addr = 32'h20;
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        check("rstwait_ack_in_reset", {31'd0, bus2.ack}, 32'd0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        bus2.req = 1'b0;
        @(negedge clk);
        check("rstwait_ack",   {31'd0, bus2.ack}, 32'd0);
        check("rstwait_rdata", bus2.rdata, 32'd0);
        check("rstwait_wr2",   {16'd0, wr2}, 32'd0);
        check("rstwait_rd2",   {16'd0, rd2}, 32'd0);
        check("rstwait_perr",  {31'd0, perr2}, 32'd0);
        @(posedge clk); #1;

        // FSM resumes after reset; memory contents survive it
        xfer2(CMD_READ, 32'h20, 32'h0, rd);
        check("rstwait_mem_kept", rd, 32'h5555_AAAA);
        check("rd2_after_reset_read", {16'd0, rd2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
